// File: rtl/pin_gen.sv
// pin_gen: timestamped pulse request FIFO feeding an 8-bin-per-cycle
// serializer word generator (transmit side of pin_capt).
module pin_gen #(
    parameter int DELAY_W    = 8,
    parameter int WIDTH_W    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk600,
    input  logic               rst,
    input  logic               str,
    input  logic [2:0]         ptime,
    input  logic [DELAY_W-1:0] pdelay,
    input  logic [WIDTH_W-1:0] pwidth,
    output logic               ready,
    output logic [7:0]         pin_word,
    output logic               busy,
    output logic               ovf
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int RW = (WIDTH_W > 4) ? WIDTH_W : 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HIGH
    } state_t;

    // Request storage
    logic [2:0]         mem_pt_q [FIFO_DEPTH];
    logic [DELAY_W-1:0] mem_pd_q [FIFO_DEPTH];
    logic [WIDTH_W-1:0] mem_pw_q [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    state_t             state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [WIDTH_W-1:0] rem_q, rem_d;
    logic [2:0]         sb_q, sb_d;
    logic [7:0]         word_q, word_d;

    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic [2:0]         head_pt;
    logic [DELAY_W-1:0] head_pd;
    logic [WIDTH_W-1:0] head_pw;

    logic [RW-1:0] rem_x;
    logic [RW-1:0] avail;
    logic [3:0]    first_n;
    logic [3:0]    full_n;
    logic [7:0]    first_word;
    logic [7:0]    full_word;

    // n low bits set, n in 0..8
    function automatic logic [7:0] ones(input logic [3:0] n);
        logic [8:0] t;
        t = (9'd1 << n) - 9'd1;
        return t[7:0];
    endfunction

    assign fifo_empty = (count_q == '0);
    assign ready      = (count_q != CW'(FIFO_DEPTH));
    assign push       = str && ready;
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign ovf        = ovf_q;
    assign pin_word   = word_q;

    assign head_pt = mem_pt_q[rd_ptr_q];
    assign head_pd = mem_pd_q[rd_ptr_q];
    assign head_pw = mem_pw_q[rd_ptr_q];

    // Bins still owed, and bins available in the start word
    assign rem_x = RW'(rem_q);
    assign avail = RW'(4'd8 - {1'b0, sb_q});

    assign first_n    = (rem_x < avail) ? rem_x[3:0] : avail[3:0];
    assign full_n     = (rem_x < RW'(8)) ? rem_x[3:0] : 4'd8;
    assign first_word = ones(first_n) << sb_q;
    assign full_word  = ones(full_n);

    // Write the accepted request into storage (data needs no reset)
    always_ff @(posedge clk600) begin
        if (push) begin
            mem_pt_q[wr_ptr_q] <= ptime;
            mem_pd_q[wr_ptr_q] <= pdelay;
            mem_pw_q[wr_ptr_q] <= pwidth;
        end
    end

    // FIFO pointer, occupancy and overflow next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = str && !ready;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer, occupancy and overflow registers
    always_ff @(posedge clk600 or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Pulse FSM next-state and serializer word
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        sb_d    = sb_q;
        word_d  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty && (head_pw != '0)) begin
                    cnt_d   = head_pd;
                    rem_d   = head_pw;
                    sb_d    = head_pt;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DELAY_W'(1);
                end else begin
                    word_d  = first_word;
                    rem_d   = WIDTH_W'(rem_x - RW'(first_n));
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (rem_q != '0) begin
                    word_d = full_word;
                    rem_d  = WIDTH_W'(rem_x - RW'(full_n));
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pulse FSM registers; reset clears the output word immediately
    always_ff @(posedge clk600 or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            sb_q    <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            sb_q    <= sb_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: tb/tb_pin_gen.sv
// tb_pin_gen: directed-vector bench for pin_gen.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_pin_gen;

    logic       clk600 = 1'b0;
    logic       rst;
    logic       str;
    logic [2:0] ptime;
    logic [7:0] pdelay;
    logic [7:0] pwidth;
    logic       ready;
    logic [7:0] pin_word;
    logic       busy;
    logic       ovf;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] cap [64];

    always #5 clk600 = ~clk600;

    pin_gen #(
        .DELAY_W   (8),
        .WIDTH_W   (8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk600  (clk600),
        .rst     (rst),
        .str     (str),
        .ptime   (ptime),
        .pdelay  (pdelay),
        .pwidth  (pwidth),
        .ready   (ready),
        .pin_word(pin_word),
        .busy    (busy),
        .ovf     (ovf)
    );

    task automatic tick();
        @(posedge clk600);
        #1;
    endtask

    task automatic drive(input logic s, input logic [2:0] t,
                         input logic [7:0] d, input logic [7:0] w);
        str    = s;
        ptime  = t;
        pdelay = d;
        pwidth = w;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            cap[i] = pin_word;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 3'd0, 8'd0, 8'd0);
        tick();
        tick();
        vectors++;
        if (pin_word !== 8'h00) begin
            errors++;
            $display("FAIL reset_word: got %h want 00", pin_word);
        end
        vectors++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", ready);
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        vectors++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_basic();
        drive(1'b1, 3'd3, 8'd0, 8'd2);
        tick();
        drive(1'b0, 3'd0, 8'd0, 8'd0);
        tick();
        vectors++;
        if (pin_word !== 8'h00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_n1: got %h/%b want 00/1", pin_word, busy);
        end
        tick();
        vectors++;
        if (pin_word !== 8'b0001_1000) begin
            errors++;
            $display("FAIL basic_n2: got %b want 00011000", pin_word);
        end
        tick();
        vectors++;
        if (pin_word !== 8'h00) begin
            errors++;
            $display("FAIL basic_n3: got %h want 00", pin_word);
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_n4: got %b want 0", busy);
        end
    endtask

    task automatic test_delay_span();
        logic [7:0] exp [6];
        exp = '{8'h00, 8'h00, 8'hC0, 8'hFF, 8'h03, 8'h00};
        drive(1'b1, 3'd6, 8'd1, 8'd12);
        tick();
        drive(1'b0, 3'd0, 8'd0, 8'd0);
        capture(6);
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (cap[k] !== exp[k]) begin
                errors++;
                $display("FAIL span_w%0d: got %h want %h", k, cap[k], exp[k]);
            end
        end
    endtask

    task automatic test_edges();
        logic [7:0] exp_a [3];
        logic [7:0] exp_b [3];
        exp_a = '{8'h00, 8'hFF, 8'h00};
        exp_b = '{8'h00, 8'h80, 8'h00};
        drive(1'b1, 3'd0, 8'd0, 8'd8);
        tick();
        drive(1'b0, 3'd0, 8'd0, 8'd0);
        capture(3);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (cap[k] !== exp_a[k]) begin
                errors++;
                $display("FAIL edge_bin0_w%0d: got %h want %h", k, cap[k], exp_a[k]);
            end
        end
        drive(1'b1, 3'd7, 8'd0, 8'd1);
        tick();
        drive(1'b0, 3'd0, 8'd0, 8'd0);
        capture(3);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (cap[k] !== exp_b[k]) begin
                errors++;
                $display("FAIL edge_bin7_w%0d: got %h want %h", k, cap[k], exp_b[k]);
            end
        end
    endtask

    task automatic test_max_width();
        logic [7:0] e;
        drive(1'b1, 3'd5, 8'd0, 8'd255);
        tick();
        drive(1'b0, 3'd0, 8'd0, 8'd0);
        capture(36);
        for (int k = 0; k < 36; k++) begin
            if (k == 1)
                e = 8'hE0;
            else if (k >= 2 && k <= 32)
                e = 8'hFF;
            else if (k == 33)
                e = 8'h0F;
            else
                e = 8'h00;
            vectors++;
            if (cap[k] !== e) begin
                errors++;
                $display("FAIL maxw_w%0d: got %h want %h", k, cap[k], e);
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL maxw_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        drive(1'b1, 3'd0, 8'd10, 8'd1);
        tick();
        drive(1'b0, 3'd0, 8'd0, 8'd0);
        tick();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 3'(i), 8'd0, 8'd1);
            tick();
            if (i == 3) begin
                vectors++;
                if (ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready3: got %b want 1", ready);
                end
            end
            if (i == 4) begin
                vectors++;
                if (ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_ready4: got %b want 0", ready);
                end
                vectors++;
                if (ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_ovf4: got %b want 0", ovf);
                end
            end
            if (i == 5) begin
                vectors++;
                if (ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ovf5: got %b want 1", ovf);
                end
            end
        end
        drive(1'b0, 3'd0, 8'd0, 8'd0);
        tick();
        vectors++;
        if (ovf !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_after: ovf/ready got %b/%b want 0/0", ovf, ready);
        end
        capture(22);
        for (int k = 0; k < 22; k++) begin
            unique case (k)
                4:       e = 8'h01;
                7:       e = 8'h02;
                10:      e = 8'h04;
                13:      e = 8'h08;
                16:      e = 8'h10;
                default: e = 8'h00;
            endcase
            vectors++;
            if (cap[k] !== e) begin
                errors++;
                $display("FAIL b2b_w%0d: got %h want %h", k, cap[k], e);
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_null();
        logic [7:0] exp_a [6];
        logic [7:0] exp_b [6];
        exp_a = '{8'h01, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00};
        exp_b = '{8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00};
        drive(1'b1, 3'd0, 8'd0, 8'd1);
        tick();
        drive(1'b1, 3'd7, 8'd0, 8'd1);
        tick();
        drive(1'b0, 3'd0, 8'd0, 8'd0);
        capture(6);
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (cap[k] !== exp_a[k]) begin
                errors++;
                $display("FAIL nonull_w%0d: got %h want %h", k, cap[k], exp_a[k]);
            end
        end
        drive(1'b1, 3'd0, 8'd0, 8'd1);
        tick();
        drive(1'b1, 3'd4, 8'd3, 8'd0);
        tick();
        drive(1'b1, 3'd7, 8'd0, 8'd1);
        tick();
        drive(1'b0, 3'd0, 8'd0, 8'd0);
        vectors++;
        if (pin_word !== 8'h01) begin
            errors++;
            $display("FAIL null_first: got %h want 01", pin_word);
        end
        capture(6);
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (cap[k] !== exp_b[k]) begin
                errors++;
                $display("FAIL null_w%0d: got %h want %h", k, cap[k], exp_b[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 3'd0, 8'd0, 8'd40);
        tick();
        drive(1'b1, 3'd1, 8'd0, 8'd1);
        tick();
        drive(1'b1, 3'd2, 8'd0, 8'd1);
        tick();
        drive(1'b0, 3'd0, 8'd0, 8'd0);
        tick();
        vectors++;
        if (pin_word !== 8'hFF || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got %h/%b want FF/1", pin_word, busy);
        end
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if (pin_word !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_word: got %h want 00", pin_word);
        end
        vectors++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_flags: ready/busy got %b/%b want 1/0", ready, busy);
        end
        tick();
        tick();
        rst = 1'b0;
        capture(20);
        for (int k = 0; k < 20; k++) begin
            vectors++;
            if (cap[k] !== 8'h00) begin
                errors++;
                $display("FAIL rstmid_post_w%0d: got %h want 00", k, cap[k]);
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_busy: got %b want 0", busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 3'd0, 8'd0, 8'd0);
        test_reset();
        test_basic();
        test_delay_span();
        test_edges();
        test_max_width();
        test_back_to_back();
        test_null();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
